// File: rtl/sync_edge_filter.sv
// sync_edge_filter: per-channel multi-flop synchroniser with optional
// glitch filter and single-cycle rise/fall edge pulses.
// Optional feature macro: SYNC_GLITCH_FILTER_EN
//   defined   -> each channel needs FILT_LEN consecutive differing synchronised
//                samples before sig_filt takes the new level
//   undefined -> sig_filt is the synchronised level itself (FILT_LEN unused)
module sync_edge_filter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned STAGES   = 2,
    parameter int unsigned FILT_LEN = 4,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] sig_sync,
    output logic [WIDTH-1:0] sig_filt,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Elaboration-time parameter range checks
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("sync_edge_filter: WIDTH must be 1..32");
    end
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
        $error("sync_edge_filter: STAGES must be 2..4");
    end
    if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_bad_filt_len
        $error("sync_edge_filter: FILT_LEN must be 1..255");
    end

    // Stage 0 is the first flop after the asynchronous input, stage STAGES-1 the last
    logic [STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]             filt_d;

    // Synchroniser chain: shift every channel one stage per edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{{WIDTH{RST_VAL}}}};
        end else begin
            chain <= {chain[STAGES-2:0], sig};
        end
    end

    assign sig_sync = chain[STAGES-1];

`ifdef SYNC_GLITCH_FILTER_EN
    localparam int unsigned CW = $clog2(FILT_LEN + 1);

    logic [WIDTH-1:0] filt_q;

    // One independent stability counter and filtered level per channel
    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        logic [CW-1:0] cnt;

        // Accept a new level only after FILT_LEN consecutive differing samples
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt       <= '0;
                filt_q[g] <= RST_VAL;
            end else if (sig_sync[g] == filt_q[g]) begin
                cnt <= '0;
            end else if (cnt == CW'(FILT_LEN - 1)) begin
                filt_q[g] <= sig_sync[g];
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign sig_filt = filt_q;
`else
    // Filter compiled out: the synchronised level is the filtered level
    assign sig_filt = sig_sync;
`endif

    // Previous filtered level for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            filt_d <= {WIDTH{RST_VAL}};
        end else begin
            filt_d <= sig_filt;
        end
    end

    // Edge pulses are pure functions of two registers; mutually exclusive per bit
    assign rise = sig_filt & ~filt_d;
    assign fall = ~sig_filt & filt_d;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Bench for sync_edge_filter (WIDTH=4, STAGES=2, FILT_LEN=4, RST_VAL=0).
// Reference model works on histories of applied inputs: the synchronised
// level is the input from STAGES edges ago (or 0 if a reset edge intervened),
// and the filtered level flips only when the last FL synchronised samples all
// carry the opposite level.
module tb_sync_edge_filter;

    localparam int ST = 2;
`ifdef SYNC_GLITCH_FILTER_EN
    localparam int FL = 4;
`else
    localparam int FL = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] sig;
    logic [3:0] sig_sync;
    logic [3:0] sig_filt;
    logic [3:0] rise;
    logic [3:0] fall;

    int checks = 0;
    int errors = 0;

    logic [3:0] in_hist[$];
    bit         rstn_hist[$];
    logic [3:0] sync_hist[$];
    logic [3:0] filt_m;
    logic [3:0] filtd_m;

    sync_edge_filter #(
        .WIDTH   (4),
        .STAGES  (2),
        .FILT_LEN(4),
        .RST_VAL (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sig     (sig),
        .sig_sync(sig_sync),
        .sig_filt(sig_filt),
        .rise    (rise),
        .fall    (fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Apply inputs for one edge, advance the model, then check all outputs
    task automatic tick(input logic [3:0] s, input logic r);
        int         n;
        bit         rs;
        logic [3:0] se;
        logic [3:0] a1;
        logic [3:0] a0;
        logic [3:0] prev;
        sig   = s;
        rst_n = r;
        @(posedge clk);
        in_hist.push_back(s);
        rstn_hist.push_back(r);
        n = in_hist.size() - 1;
        rs = 1'b0;
        for (int k = n - ST + 1; k <= n; k++) begin
            if (k < 0 || !rstn_hist[k]) rs = 1'b1;
        end
        se   = rs ? 4'h0 : in_hist[n - ST + 1];
        prev = filt_m;
        if (!r) begin
            filt_m  = 4'h0;
            filtd_m = 4'h0;
        end else begin
            filtd_m = prev;
            if (FL == 0) begin
                filt_m = se;
            end else if (n >= FL) begin
                a1 = 4'hF;
                a0 = 4'hF;
                for (int k = n - FL; k < n; k++) begin
                    a1 = a1 & sync_hist[k];
                    a0 = a0 & ~sync_hist[k];
                end
                filt_m = (prev & ~a0) | (~prev & a1);
            end
        end
        sync_hist.push_back(se);
        #1;
        chk("sig_sync", sig_sync, se);
        chk("sig_filt", sig_filt, filt_m);
        chk("rise", rise, filt_m & ~filtd_m);
        chk("fall", fall, ~filt_m & filtd_m);
        chk("rise_fall_excl", rise & fall, 4'h0);
    endtask

    initial begin
        int         ones;
        int         pulses;
        logic [3:0] cur;
        logic [3:0] mask;
        int         pr;
        filt_m  = 4'h0;
        filtd_m = 4'h0;
        rst_n   = 1'b0;
        sig     = 4'h0;

        // Reset with all inputs high: everything held at 0
        tick(4'hF, 1'b0);
        tick(4'hF, 1'b0);
        chk("rst_sync", sig_sync, 4'h0);
        chk("rst_filt", sig_filt, 4'h0);
        chk("rst_edges", rise | fall, 4'h0);

        // Release: sync after STAGES edges, filtered after STAGES+FILT_LEN, one rise
        for (int k = 1; k <= 9; k++) begin
            tick(4'hF, 1'b1);
            chk("rel_sync", sig_sync, (k >= ST) ? 4'hF : 4'h0);
            chk("rel_filt", sig_filt, (k >= ST + FL) ? 4'hF : 4'h0);
            chk("rel_rise", rise, (k == ST + FL) ? 4'hF : 4'h0);
        end

        // Settle to channel 2 high only
        for (int k = 0; k < 10; k++) tick(4'h4, 1'b1);
        chk("settle_filt", sig_filt, 4'h4);

        // Three-cycle glitch on channel 0
        ones   = 0;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick((k < 3) ? 4'h5 : 4'h4, 1'b1);
            ones   += int'(sig_sync[0]);
            pulses += int'(rise[0]) + int'(fall[0]);
        end
        chk("glitch_sync_len", 4'(ones), 4'd3);
        chk("glitch_pulses", 4'(pulses), (FL > 3) ? 4'd0 : 4'd2);

        // One-cycle glitch on channel 1
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            tick((k == 0) ? 4'h6 : 4'h4, 1'b1);
            pulses += int'(rise[1]) + int'(fall[1]);
        end
        chk("glitch1_pulses", 4'(pulses), (FL > 1) ? 4'd0 : 4'd2);

        // Channel 1 rises and channel 2 falls in the same cycle
        for (int k = 1; k <= 9; k++) begin
            tick(4'h2, 1'b1);
            chk("ind_rise", rise, (k == ST + FL) ? 4'h2 : 4'h0);
            chk("ind_fall", fall, (k == ST + FL) ? 4'h4 : 4'h0);
        end

        // Channel 3 rises; reset hits while its count is at 2
        tick(4'hA, 1'b1);
        tick(4'hA, 1'b1);
        tick(4'hA, 1'b1);
        tick(4'hA, 1'b1);
        tick(4'hA, 1'b0);
        chk("midrst_filt", sig_filt, 4'h0);
        chk("midrst_edges", rise | fall, 4'h0);
        for (int k = 1; k <= 9; k++) begin
            tick(4'hA, 1'b1);
            chk("midrst_sync3", {3'b000, sig_sync[3]}, (k >= ST) ? 4'h1 : 4'h0);
            chk("midrst_filt3", {3'b000, sig_filt[3]}, (k >= ST + FL) ? 4'h1 : 4'h0);
        end

        // Randomised traffic with varying toggle rates and occasional resets
        cur = 4'hA;
        for (int k = 0; k < 600; k++) begin
            pr = 1 << ((k / 75) % 4 + 1);
            mask = 4'h0;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(pr - 1, 0) == 0) mask[b] = 1'b1;
            end
            cur = cur ^ mask;
            tick(cur, ($urandom_range(99, 0) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
